dn_readout_fifo: RTL and testbench
==================================

# dn_readout_fifo

Buffers the 14-bit delay results (`dn`) produced by the algorithm core so that the SPI serializer can read them out at its own pace. It sits between the algorithm core output and the parallel-to-serial MISO stage. Each accepted result is tagged with a 2-bit sequence number so the host can detect dropped frames. The block also counts overflow and underflow events.

## Interface
- `DEPTH`, 8: number of entries; must be a power of two, minimum 2.
- `DN_W`, 14: result width.
- `SEQ_W`, 2: sequence tag width.
- `clk` in 1: system clock, the same clock that drives the algorithm core and the SPI stages.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: synchronous clear of the FIFO contents.
- `din` in DN_W: result from the algorithm core.
- `din_valid` in 1: single-cycle pulse meaning `din` is a new result.
- `rd_req` in 1: single-cycle pulse from the serializer at the start of a frame.
- `dout` out SEQ_W+DN_W: `{seq, data}` presented to the serializer.
- `dout_valid` out 1: `dout` holds a freshly popped word.
- `empty` out 1: FIFO holds no entries.
- `full` out 1: FIFO holds DEPTH entries.
- `level` out $clog2(DEPTH)+1: current occupancy.
- `ovf_cnt` out 8: count of dropped writes, saturating.
- `unf_cnt` out 8: count of reads made while empty, saturating.

## Operation
- **Storage:** circular buffer with `wr_ptr` and `rd_ptr` of $clog2(DEPTH) bits that wrap modulo DEPTH, plus a separate occupancy counter `level`.
- **Write:**
  - A `din_valid` pulse is accepted when `level < DEPTH`.
  - An accepted write stores `{seq_cnt, din}`, then increments `wr_ptr` and `seq_cnt`.
  - `seq_cnt` wraps from 3 to 0.
- **Overflow:**
  - When `din_valid` arrives while full and there is no `rd_req` in the same cycle, the new word is dropped.
  - `ovf_cnt` increments, saturating at 255.
  - `seq_cnt` still increments, so the host sees a gap in the tags.
- **Read:**
  - An `rd_req` pulse while `level > 0` loads the entry at `rd_ptr` into the `dout` register.
  - `dout_valid` is asserted for 1 cycle and `rd_ptr` increments.
- **Underflow:**
  - An `rd_req` pulse while empty leaves `dout` holding its last value and keeps `dout_valid` at 0.
  - `unf_cnt` increments, saturating at 255.
- **Simultaneous write and read:**
  - When full, both the write and the read succeed and `level` is unchanged.
  - When empty, the read is an underflow and the write is accepted, giving `level` = 1. There is no bypass path.
- **Flush:**
  - Pointers and `level` go to 0.
  - `dout_valid` goes to 0.
  - `seq_cnt`, `ovf_cnt`, `unf_cnt` and `dout` are kept.
  - Flush wins over any write or read in the same cycle.
- **Reset:** resets everything, including `seq_cnt` and both counters.

## Timing
- **Reset values:**
  - `dout` = 0, `dout_valid` = 0, `level` = 0.
  - `empty` = 1, `full` = 0.
  - `ovf_cnt` = 0, `unf_cnt` = 0, `seq_cnt` = 0.
- **Write latency:** a `din_valid` in cycle N is reflected in `level`, `empty` and `full` in cycle N+1.
- **Read latency:** an `rd_req` in cycle N gives `dout` and `dout_valid` = 1 in cycle N+1. `dout_valid` drops in N+2 unless another read succeeds in N+1.
- **Back-to-back operation:**
  - Back-to-back `rd_req` pulses are legal and pop 1 word per cycle.
  - Back-to-back `din_valid` pulses are legal and push 1 word per cycle.
- **Derived flags:** `empty` and `full` are registered outputs derived from next-state `level`, so they never lag `level`.
- **`rst` mid-operation:** takes effect at the next `clk` edge and overrides `flush`, `din_valid` and `rd_req`.

## Structure
- **Package `dn_pkg`:**
  - `DN_W` = 14, `SEQ_W` = 2.
  - The `dn_word_t` packed struct `{seq, data}`.
  - `CNT_W` = 8.
- **Sub-module `dn_fifo_mem`:**
  - DEPTH x (SEQ_W+DN_W) register array.
  - Synchronous write port.
  - Combinational read port, sampled by the parent's `dout` register.
- **Parent module:** holds the pointers, `level`, the saturating counters and the flush/reset priority logic.

## Test plan
- **Reset and single transfer:** `rst`, then `din_valid` with `din` = 0x1ABC, then `rd_req`. Required:
  - `dout` = 0x1ABC with seq 0, i.e. 16'h1ABC.
  - `dout_valid` high for 1 cycle, one cycle after `rd_req`.
  - `empty` = 1 afterwards.
- **Fill and overflow:** write 10 words 0x0001..0x000A with DEPTH = 8 and no reads. Required:
  - `full` = 1 and `ovf_cnt` = 2.
  - 8 reads return data 1..8 with seq 0,1,2,3,0,1,2,3.
  - A following write gets seq 2, showing the gap.
- **Underflow:** 3 `rd_req` pulses while empty. Required:
  - `unf_cnt` = 3.
  - `dout_valid` never 1.
  - `dout` unchanged.
- **Simultaneous write and read at full:** full FIFO, then `din_valid` and `rd_req` in the same cycle. Required:
  - `level` stays 8 and `ovf_cnt` is unchanged.
  - The oldest word is output.
  - The new word is read out last.
- **Flush mid-stream:** 5 entries, `flush` asserted together with `rd_req` and `din_valid`. Required:
  - `level` = 0 and `dout_valid` = 0.
  - Counters and `seq_cnt` keep their values.
  - The next write carries the continuing seq.
- **Counter saturation:** 300 underflow reads give `unf_cnt` = 255. A subsequent `rst` clears it to 0.

Source files
------------

// File: rtl/dn_pkg.sv
// Shared widths, the readout word layout and a saturating counter helper.
package dn_pkg;

  localparam int unsigned DN_W  = 14;
  localparam int unsigned SEQ_W = 2;
  localparam int unsigned CNT_W = 8;

  typedef struct packed {
    logic [SEQ_W-1:0] seq;
    logic [DN_W-1:0]  data;
  } dn_word_t;

  // Increment that sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + CNT_W'(1);
  endfunction

endpackage

// File: rtl/dn_fifo_mem.sv
// Register-array storage for the readout FIFO: synchronous write, combinational read.
module dn_fifo_mem #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata_c
);

  logic [W-1:0] mem [DEPTH];

  // Write port; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port; old data is seen when reading and writing one slot together.
  assign rdata_c = mem[raddr];

endmodule

// File: rtl/dn_readout_fifo.sv
// Result FIFO between the algorithm core and the SPI serializer, with
// sequence tagging and saturating overflow/underflow counters.
module dn_readout_fifo
  import dn_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned DN_W  = dn_pkg::DN_W,
  parameter int unsigned SEQ_W = dn_pkg::SEQ_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [DN_W-1:0]            din,
  input  logic                       din_valid,
  input  logic                       rd_req,
  output logic [SEQ_W+DN_W-1:0]      dout,
  output logic                       dout_valid,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     level,
  output logic [CNT_W-1:0]           ovf_cnt,
  output logic [CNT_W-1:0]           unf_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned WW = SEQ_W + DN_W;

  logic [AW-1:0]    wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [LW-1:0]    level_nxt;
  logic [SEQ_W-1:0] seq_cnt, seq_nxt;
  logic [CNT_W-1:0] ovf_nxt, unf_nxt;
  logic [WW-1:0]    dout_nxt, rd_word_c;
  logic             dout_valid_nxt;
  logic             rd_ok_c, wr_ok_c, we_c;

  dn_fifo_mem #(
    .DEPTH (DEPTH),
    .W     (WW)
  ) u_mem (
    .clk     (clk),
    .we      (we_c),
    .waddr   (wr_ptr),
    .wdata   ({seq_cnt, din}),
    .raddr   (rd_ptr),
    .rdata_c (rd_word_c)
  );

  // Next-state: a read frees a slot for a same-cycle write; flush beats both.
  always_comb begin
    wr_ptr_nxt     = wr_ptr;
    rd_ptr_nxt     = rd_ptr;
    level_nxt      = level;
    seq_nxt        = seq_cnt;
    ovf_nxt        = ovf_cnt;
    unf_nxt        = unf_cnt;
    dout_nxt       = dout;
    dout_valid_nxt = 1'b0;

    rd_ok_c = rd_req && (level != '0);
    wr_ok_c = din_valid && ((level != LW'(DEPTH)) || rd_ok_c);
    we_c    = wr_ok_c && !flush;

    if (flush) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      level_nxt  = '0;
    end else begin
      if (wr_ok_c)               wr_ptr_nxt = wr_ptr + AW'(1);
      if (din_valid)             seq_nxt    = seq_cnt + SEQ_W'(1);
      if (din_valid && !wr_ok_c) ovf_nxt    = sat_inc(ovf_cnt);
      if (rd_ok_c) begin
        rd_ptr_nxt     = rd_ptr + AW'(1);
        dout_nxt       = rd_word_c;
        dout_valid_nxt = 1'b1;
      end else if (rd_req) begin
        unf_nxt = sat_inc(unf_cnt);
      end
      level_nxt = level + LW'(wr_ok_c) - LW'(rd_ok_c);
    end
  end

  // State and registered outputs; flags come from next-state level.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      seq_cnt    <= '0;
      ovf_cnt    <= '0;
      unf_cnt    <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      empty      <= 1'b1;
      full       <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      level      <= level_nxt;
      seq_cnt    <= seq_nxt;
      ovf_cnt    <= ovf_nxt;
      unf_cnt    <= unf_nxt;
      dout       <= dout_nxt;
      dout_valid <= dout_valid_nxt;
      empty      <= (level_nxt == '0);
      full       <= (level_nxt == LW'(DEPTH));
    end
  end

endmodule

// File: tb/tb_dn_readout_fifo.sv
// Bench for dn_readout_fifo: queue reference model plus vector table and corner sequences.
module tb_dn_readout_fifo;
  import dn_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [13:0] din = '0;
  logic        din_valid = 1'b0;
  logic        rd_req = 1'b0;
  logic [15:0] dout;
  logic        dout_valid;
  logic        empty;
  logic        full;
  logic [3:0]  level;
  logic [7:0]  ovf_cnt;
  logic [7:0]  unf_cnt;

  dn_readout_fifo #(.DEPTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .din        (din),
    .din_valid  (din_valid),
    .rd_req     (rd_req),
    .dout       (dout),
    .dout_valid (dout_valid),
    .empty      (empty),
    .full       (full),
    .level      (level),
    .ovf_cnt    (ovf_cnt),
    .unf_cnt    (unf_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  logic [15:0] q[$];
  logic [1:0]  m_seq;
  int          m_ovf, m_unf;
  logic [15:0] m_dout;
  logic        m_dv;

  typedef struct {
    logic        fl;
    logic        dv;
    logic [13:0] din;
    logic        rr;
    int          lvl;
    logic        full;
    int          ovf;
    logic        chk_dout;
    logic [15:0] dout;
  } vec_t;

  vec_t tbl[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_seq  = '0;
    m_ovf  = 0;
    m_unf  = 0;
    m_dout = '0;
    m_dv   = 1'b0;
  endtask

  // Reset asserted together with every other control to show it overrides them.
  task automatic do_reset();
    rst = 1'b1; flush = 1'b1; din_valid = 1'b1; rd_req = 1'b1; din = 14'h3FFF;
    @(posedge clk); #1;
    rst = 1'b0; flush = 1'b0; din_valid = 1'b0; rd_req = 1'b0; din = '0;
    model_reset();
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_dout_valid", 32'(dout_valid), 32'h0);
    chk("rst_level", 32'(level), 32'h0);
    chk("rst_empty", 32'(empty), 32'h1);
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_ovf", 32'(ovf_cnt), 32'h0);
    chk("rst_unf", 32'(unf_cnt), 32'h0);
  endtask

  // One clock of stimulus; model predicts, then all outputs are compared.
  task automatic step(input logic fl, input logic dv, input logic [13:0] d, input logic rr);
    logic rd_ok, wr_ok;
    rd_ok = !fl && rr && (q.size() > 0);
    wr_ok = !fl && dv && ((q.size() < 8) || rd_ok);
    m_dv  = rd_ok;
    if (rd_ok) m_dout = q.pop_front();
    if (fl) begin
      q.delete();
    end else begin
      if (wr_ok) q.push_back({m_seq, d});
      if (dv) begin
        if (!wr_ok && m_ovf < 255) m_ovf++;
        m_seq = m_seq + 2'd1;
      end
      if (rr && !rd_ok && m_unf < 255) m_unf++;
    end
    flush = fl; din_valid = dv; din = d; rd_req = rr;
    @(posedge clk); #1;
    flush = 1'b0; din_valid = 1'b0; din = '0; rd_req = 1'b0;
    chk("dout_valid", 32'(dout_valid), 32'(m_dv));
    chk("dout", 32'(dout), 32'(m_dout));
    chk("level", 32'(level), 32'(q.size()));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("full", 32'(full), 32'(q.size() == 8));
    chk("ovf_cnt", 32'(ovf_cnt), 32'(m_ovf));
    chk("unf_cnt", 32'(unf_cnt), 32'(m_unf));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Vector table: fill 10 words into an 8-deep FIFO, drain 8, write one more.
    for (int i = 0; i < 10; i++)
      tbl[i] = '{1'b0, 1'b1, 14'(i + 1), 1'b0, (i < 8) ? i + 1 : 8,
                 (i >= 7), (i >= 8) ? i - 7 : 0, 1'b0, 16'h0};
    for (int k = 0; k < 8; k++)
      tbl[10 + k] = '{1'b0, 1'b0, 14'h0, 1'b1, 7 - k, 1'b0, 2, 1'b1,
                      {2'(k % 4), 14'(k + 1)}};
    tbl[18] = '{1'b0, 1'b1, 14'h00B, 1'b0, 1, 1'b0, 2, 1'b0, 16'h0};

    // Reset and single transfer
    do_reset();
    step(1'b0, 1'b1, 14'h1ABC, 1'b0);
    step(1'b0, 1'b0, 14'h0, 1'b1);
    chk("single_dout", 32'(dout), 32'h1ABC);
    chk("single_valid", 32'(dout_valid), 32'h1);
    step(1'b0, 1'b0, 14'h0, 1'b0);
    chk("single_valid_drop", 32'(dout_valid), 32'h0);
    chk("single_empty", 32'(empty), 32'h1);

    // Fill, overflow and seq gap from the table
    do_reset();
    for (int i = 0; i < 19; i++) begin
      step(tbl[i].fl, tbl[i].dv, tbl[i].din, tbl[i].rr);
      chk("tbl_level", 32'(level), 32'(tbl[i].lvl));
      chk("tbl_full", 32'(full), 32'(tbl[i].full));
      chk("tbl_ovf", 32'(ovf_cnt), 32'(tbl[i].ovf));
      if (tbl[i].chk_dout) begin
        chk("tbl_valid", 32'(dout_valid), 32'h1);
        chk("tbl_dout", 32'(dout), 32'(tbl[i].dout));
      end
    end
    step(1'b0, 1'b0, 14'h0, 1'b1);
    chk("gap_seq_word", 32'(dout), 32'h800B);

    // Underflow: three reads while empty
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 14'h0, 1'b1);
      chk("unf_valid", 32'(dout_valid), 32'h0);
      chk("unf_dout_hold", 32'(dout), 32'h800B);
    end
    chk("unf_cnt3", 32'(unf_cnt), 32'h3);

    // Simultaneous write and read while full
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 14'(32'h100 + i), 1'b0);
    chk("sim_full", 32'(full), 32'h1);
    step(1'b0, 1'b1, 14'h1FF, 1'b1);
    chk("sim_level", 32'(level), 32'h8);
    chk("sim_ovf", 32'(ovf_cnt), 32'h2);
    chk("sim_oldest", 32'(dout), 32'hC100);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 14'h0, 1'b1);
    chk("sim_newest_last", 32'(dout), 32'hC1FF);
    chk("sim_drained", 32'(empty), 32'h1);

    // Flush mid-stream with a read in flight
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 14'(32'h200 + i), 1'b0);
    step(1'b0, 1'b0, 14'h0, 1'b1);
    step(1'b1, 1'b1, 14'h2AA, 1'b1);
    chk("flush_level", 32'(level), 32'h0);
    chk("flush_valid", 32'(dout_valid), 32'h0);
    chk("flush_ovf", 32'(ovf_cnt), 32'h2);
    chk("flush_unf", 32'(unf_cnt), 32'h3);
    step(1'b0, 1'b1, 14'h2BB, 1'b0);
    step(1'b0, 1'b0, 14'h0, 1'b1);
    chk("flush_seq_cont", 32'(dout), 32'h42BB);

    // Underflow counter saturation, then reset clears it
    for (int i = 0; i < 300; i++) step(1'b0, 1'b0, 14'h0, 1'b1);
    chk("unf_sat", 32'(unf_cnt), 32'd255);
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
